// File: rtl/fp_mac_pkg.sv
// Shared fp32 MAC definitions: format constants and the result-tracking tag.
package fp_mac_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h00000000;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F800000;

  // Width of the element count carried alongside each in-flight operand pair.
  localparam int TAG_LEN_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [TAG_LEN_W-1:0] len;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mac_tag_pipe.sv
// Depth-D shift register of tags that follows operands through the MAC so each
// MAC result can be matched with the element that produced it.
module mac_tag_pipe #(
  parameter int D = 5,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stages [D];

  // Shift only when enabled so the tags stay in lockstep with the frozen MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) stages[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < D; i++) stages[i] <= '0;
    end else if (en) begin
      stages[0] <= din;
      for (int i = 1; i < D; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[D-1];

endmodule

// File: rtl/fp_dot_sequencer.sv
// Feeds fp32 operand pairs to an external MAC and collects one dot product per
// vector, using a tag pipe to find the result and ena to apply backpressure.
module fp_dot_sequencer
  import fp_mac_pkg::*;
#(
  parameter int MAC_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk0,
  input  logic              clr0_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_a,
  input  logic [FP32_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_len,
  output logic              mac_ena,
  output logic              mac_clr0,
  output logic              mac_accumulate,
  output logic [FP32_W-1:0] mac_ay,
  output logic [FP32_W-1:0] mac_az,
  input  logic [FP32_W-1:0] mac_result
);

  localparam int DEPTH = MAC_LAT + 1;

  logic             advance;
  logic             accept;
  logic             first_flag;
  logic [CNT_W-1:0] count;
  tag_t             push_tag;
  tag_t             exit_tag;
  logic [TAG_W-1:0] exit_bits;

  // Whole datapath moves only when the output slot is free and the MAC is not clearing.
  always_comb begin
    advance  = !(out_valid && !out_ready) && !mac_clr0;
    accept   = in_valid && advance;
    push_tag = '0;
    if (accept) begin
      push_tag.valid = 1'b1;
      push_tag.last  = in_last;
      push_tag.len   = TAG_LEN_W'(count + CNT_W'(1));
    end
  end

  assign mac_ena  = advance;
  assign in_ready = advance;
  assign exit_tag = tag_t'(exit_bits);

  // MAC clear is held through reset, released on the first edge, and pulsed by flush.
  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) mac_clr0 <= 1'b1;
    else         mac_clr0 <= flush;
  end

  // Operand stage: real pairs when accepted, otherwise a +0.0 bubble that keeps the sum.
  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) begin
      mac_ay         <= FP32_ZERO;
      mac_az         <= FP32_ZERO;
      mac_accumulate <= 1'b0;
    end else if (flush) begin
      mac_ay         <= FP32_ZERO;
      mac_az         <= FP32_ZERO;
      mac_accumulate <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        mac_ay         <= in_a;
        mac_az         <= in_b;
        mac_accumulate <= !first_flag;
      end else begin
        mac_ay         <= FP32_ZERO;
        mac_az         <= FP32_ZERO;
        mac_accumulate <= 1'b1;
      end
    end
  end

  // Vector boundary tracking: first_flag restarts the MAC sum, count sizes the vector.
  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) begin
      first_flag <= 1'b1;
      count      <= '0;
    end else if (flush) begin
      first_flag <= 1'b1;
      count      <= '0;
    end else if (accept) begin
      first_flag <= in_last;
      count      <= in_last ? '0 : count + CNT_W'(1);
    end
  end

  mac_tag_pipe #(
    .D (DEPTH),
    .W (TAG_W)
  ) u_tag_pipe (
    .clk   (clk0),
    .rst_n (clr0_n),
    .en    (advance),
    .clr   (flush),
    .din   (push_tag),
    .dout  (exit_bits)
  );

  // Capture the MAC result when the final element's tag emerges; a new capture beats the handshake clear.
  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) begin
      out_valid <= 1'b0;
      out_data  <= FP32_ZERO;
      out_len   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= FP32_ZERO;
      out_len   <= '0;
    end else if (advance && exit_tag.valid && exit_tag.last) begin
      out_valid <= 1'b1;
      out_data  <= mac_result;
      out_len   <= CNT_W'(exit_tag.len);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Self-checking bench for fp_dot_sequencer with a behavioural integer-valued MAC.
module tb_fp_dot_sequencer;
  import fp_mac_pkg::*;

  localparam int MAC_LAT = 4;
  localparam int CNT_W   = 16;

  logic              clk0 = 1'b0;
  logic              clr0_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [CNT_W-1:0]  out_len;
  logic              mac_ena;
  logic              mac_clr0;
  logic              mac_accumulate;
  logic [31:0]       mac_ay;
  logic [31:0]       mac_az;
  logic [31:0]       mac_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          len;
    int          cyc;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  int   ref_sum = 0;
  int   ref_len = 0;
  int   last_acc_cyc = 0;

  int          mac_sum;
  logic [31:0] mac_pipe [MAC_LAT];

  fp_dot_sequencer #(
    .MAC_LAT (MAC_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk0           (clk0),
    .clr0_n         (clr0_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_len        (out_len),
    .mac_ena        (mac_ena),
    .mac_clr0       (mac_clr0),
    .mac_accumulate (mac_accumulate),
    .mac_ay         (mac_ay),
    .mac_az         (mac_az),
    .mac_result     (mac_result)
  );

  always #5 clk0 = ~clk0;

  always @(posedge clk0) cyc <= cyc + 1;

  // Integer to fp32 bits (exact for |v| < 2^24).
  function automatic logic [31:0] enc(input int v);
    int m;
    int e;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 24; i++) if (m >= (1 << i)) e = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'(m << (23 - e));
    return r;
  endfunction

  // fp32 bits of an integer value back to int.
  function automatic int dec(input logic [31:0] x);
    int e;
    int m;
    if (x[30:23] == 8'd0) return 0;
    e = int'(x[30:23]) - 127;
    m = int'({8'd0, 1'b1, x[22:0]});
    m = m >> (23 - e);
    return x[31] ? -m : m;
  endfunction

  // Behavioural MAC: sample on ena, result appears MAC_LAT-1 edges after the sample edge.
  always @(posedge clk0) begin
    if (mac_clr0) begin
      mac_sum <= 0;
      for (int i = 0; i < MAC_LAT; i++) mac_pipe[i] <= '0;
    end else if (mac_ena) begin
      mac_sum     <= (mac_accumulate ? mac_sum : 0) + dec(mac_ay) * dec(mac_az);
      mac_pipe[0] <= enc((mac_accumulate ? mac_sum : 0) + dec(mac_ay) * dec(mac_az));
      for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
  end

  assign mac_result = mac_pipe[MAC_LAT-1];

  // Record every completed output handshake.
  always @(negedge clk0) begin
    if (clr0_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      obs_q.push_back('{out_data, int'(out_len), cyc});
  end

  task automatic send_element(input int a, input int b, input logic last);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = enc(a);
    in_b     = enc(b);
    in_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk0);
      ok = in_ready;
      @(posedge clk0);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout got in_ready=%b want 1", in_ready);
    end else begin
      ref_sum += a * b;
      ref_len++;
      last_acc_cyc = cyc;
      if (last) begin
        exp_q.push_back('{enc(ref_sum), ref_len, 0});
        ref_sum = 0;
        ref_len = 0;
      end
    end
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 300) begin
      @(posedge clk0);
      t++;
    end
    #1;
    if (obs_q.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout got %0d results want %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    clr0_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || mac_ena !== 1'b0 || mac_accumulate !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got rdy=%b ov=%b ena=%b acc=%b want 0000", in_ready, out_valid, mac_ena, mac_accumulate);
    end
    checks++;
    if (out_data !== 32'h0 || out_len !== '0 || mac_ay !== 32'h0 || mac_az !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got od=%h ol=%0d ay=%h az=%h want zeros", out_data, out_len, mac_ay, mac_az);
    end
    checks++;
    if (mac_clr0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_clr0 got %b want 1", mac_clr0);
    end
    clr0_n = 1'b1;
    #2;
    checks++;
    if (mac_clr0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr0_held got %b want 1", mac_clr0);
    end
    @(posedge clk0);
    #1;
    checks++;
    if (mac_clr0 !== 1'b0 || in_ready !== 1'b1 || mac_ena !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr0_release got clr0=%b rdy=%b ena=%b want 011", mac_clr0, in_ready, mac_ena);
    end
  endtask

  task automatic test_three_ones();
    res_t r;
    res_t e;
    int   acc;
    out_ready = 1'b1;
    send_element(1, 1, 1'b0);
    send_element(1, 1, 1'b0);
    send_element(1, 1, 1'b1);
    acc = last_acc_cyc;
    wait_results(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== 32'h40400000 || r.data !== e.data) begin
        errors++;
        $display("[TB] FAIL three_ones_data got %h want 40400000", r.data);
      end
      checks++;
      if (r.len != 3) begin
        errors++;
        $display("[TB] FAIL three_ones_len got %0d want 3", r.len);
      end
      checks++;
      if (r.cyc - acc != MAC_LAT + 1) begin
        errors++;
        $display("[TB] FAIL three_ones_latency got %0d want %0d", r.cyc - acc, MAC_LAT + 1);
      end
    end
  endtask

  task automatic test_single();
    res_t r;
    res_t e;
    send_element(2, 3, 1'b1);
    wait_results(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== 32'h40C00000 || r.data !== e.data || r.len != 1) begin
        errors++;
        $display("[TB] FAIL single got %h len %0d want 40c00000 len 1", r.data, r.len);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r1;
    res_t r2;
    int   a1;
    send_element(1, 1, 1'b0);
    a1 = last_acc_cyc;
    send_element(1, 1, 1'b1);
    send_element(2, 2, 1'b1);
    checks++;
    if (last_acc_cyc - a1 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_gapless got %0d cycles want 2", last_acc_cyc - a1);
    end
    wait_results(2);
    if (obs_q.size() > 1 && exp_q.size() > 1) begin
      r1 = obs_q.pop_front();
      r2 = obs_q.pop_front();
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      checks++;
      if (r1.data !== 32'h40000000 || r1.len != 2) begin
        errors++;
        $display("[TB] FAIL b2b_first got %h len %0d want 40000000 len 2", r1.data, r1.len);
      end
      checks++;
      if (r2.data !== 32'h40800000 || r2.len != 1 || r2.cyc - r1.cyc != 1) begin
        errors++;
        $display("[TB] FAIL b2b_second got %h len %0d gap %0d want 40800000 len 1 gap 1", r2.data, r2.len, r2.cyc - r1.cyc);
      end
    end
  endtask

  task automatic test_bubbles();
    res_t r;
    res_t e;
    send_element(1, 1, 1'b0);
    repeat (3) @(posedge clk0);
    #1;
    send_element(1, 1, 1'b1);
    wait_results(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.data !== 32'h40000000 || r.data !== e.data || r.len != 2) begin
        errors++;
        $display("[TB] FAIL bubbles got %h len %0d want 40000000 len 2", r.data, r.len);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    res_t e;
    out_ready = 1'b0;
    fork
      begin
        send_element(1, 1, 1'b0);
        send_element(1, 1, 1'b1);
        for (int i = 0; i < 5; i++) send_element(1, 2, i == 4);
      end
      begin
        int t;
        logic [31:0] ay0;
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
          @(negedge clk0);
          t++;
        end
        ay0 = mac_ay;
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bp_first_timeout got out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk0);
          checks++;
          if (in_ready !== 1'b0 || mac_ena !== 1'b0 || mac_ay !== ay0) begin
            errors++;
            $display("[TB] FAIL bp_freeze got rdy=%b ena=%b ay=%h want 0 0 %h", in_ready, mac_ena, mac_ay, ay0);
          end
          checks++;
          if (out_valid !== 1'b1 || out_data !== 32'h40000000 || out_len !== 16'd2) begin
            errors++;
            $display("[TB] FAIL bp_hold got ov=%b %h len %0d want 1 40000000 len 2", out_valid, out_data, out_len);
          end
        end
        @(posedge clk0);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        r = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.data !== e.data || r.len != e.len) begin
          errors++;
          $display("[TB] FAIL bp_result%0d got %h len %0d want %h len %0d", i, r.data, r.len, e.data, e.len);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    out_ready = 1'b1;
    send_element(1, 1, 1'b0);
    send_element(1, 1, 1'b0);
    clr0_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || mac_ena !== 1'b0 || mac_accumulate !== 1'b0 ||
        mac_ay !== 32'h0 || mac_az !== 32'h0 || out_data !== 32'h0 || out_len !== '0 || mac_clr0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_values got rdy=%b ov=%b ena=%b acc=%b ay=%h az=%h od=%h ol=%0d clr0=%b want reset values",
               in_ready, out_valid, mac_ena, mac_accumulate, mac_ay, mac_az, out_data, out_len, mac_clr0);
    end
    @(posedge clk0);
    #1;
    clr0_n  = 1'b1;
    ref_sum = 0;
    ref_len = 0;
    send_element(1, 1, 1'b1);
    wait_results(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      if (r.data !== FP32_ONE || r.len != 1) begin
        errors++;
        $display("[TB] FAIL midreset_result got %h len %0d want %h len 1", r.data, r.len, FP32_ONE);
      end
    end
  endtask

  task automatic test_flush_mid();
    res_t r;
    send_element(1, 1, 1'b0);
    send_element(2, 2, 1'b0);
    flush = 1'b1;
    @(posedge clk0);
    #1;
    flush = 1'b0;
    checks++;
    if (mac_clr0 !== 1'b1 || in_ready !== 1'b0 || mac_ena !== 1'b0 || mac_ay !== 32'h0 ||
        mac_accumulate !== 1'b0 || out_data !== 32'h0 || out_len !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_values got clr0=%b rdy=%b ena=%b ay=%h acc=%b od=%h ol=%0d ov=%b want reset values",
               mac_clr0, in_ready, mac_ena, mac_ay, mac_accumulate, out_data, out_len, out_valid);
    end
    @(posedge clk0);
    #1;
    checks++;
    if (mac_clr0 !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_release got clr0=%b rdy=%b want 0 1", mac_clr0, in_ready);
    end
    ref_sum = 0;
    ref_len = 0;
    send_element(1, 1, 1'b1);
    wait_results(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      r = obs_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      if (r.data !== FP32_ONE || r.len != 1) begin
        errors++;
        $display("[TB] FAIL flush_result got %h len %0d want %h len 1", r.data, r.len, FP32_ONE);
      end
    end
  endtask

  task automatic test_random();
    res_t r;
    res_t e;
    bit   done;
    int   n_exp;
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 15; v++) begin
          int n;
          n = int'($urandom_range(1, 6));
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk0);
              #1;
            end
            send_element(int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4, k == n - 1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk0);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n_exp = exp_q.size();
    wait_results(n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (obs_q.size() > 0) begin
        r = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.data !== e.data || r.len != e.len) begin
          errors++;
          $display("[TB] FAIL random_vec%0d got %h len %0d want %h len %0d", i, r.data, r.len, e.data, e.len);
        end
      end
    end
    repeat (20) @(posedge clk0);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_extra got %0d extra results want 0", obs_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_three_ones();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_flush_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
